// File: rtl/acc_out_port.sv
// Accumulator output port: small FWFT FIFO between OUT pushes and an external valid/ready reader.
// Latency: a word pushed at edge N is on out_data with out_valid=1 right after edge N.
// Backpressure: reader stalls via out_ready; a push into a full FIFO without a pop is dropped and sets sticky overflow.

module acc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is deliberately left out of reset; only the bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

module acc_out_port #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] acc_in,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_dat;

    assign out_valid = (count != '0);
    assign full      = (count == FULL_CNT);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = load & (~full | pop);
    // Head is masked while empty so stale or never-written storage never leaks out.
    assign out_data  = out_valid ? head_dat : '0;

    acc_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (acc_in),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (load & full & ~pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_acc_out_port.sv
// Bench for acc_out_port: directed vector table, hand-written corner sequences, random traffic vs a queue model.
module tb_acc_out_port;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          reset;
    logic          load;
    logic [DW-1:0] acc_in;
    logic          full;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   count;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    acc_out_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .acc_in    (acc_in),
        .full      (full),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          load;
        logic [DW-1:0] acc;
        logic          rdy;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [AW:0]   exp_count;
        logic          exp_full;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic [AW:0] c, input logic f, input logic o);
        chk({tag, ".out_valid"}, 16'(out_valid), 16'(v));
        chk({tag, ".out_data"},  16'(out_data),  16'(d));
        chk({tag, ".count"},     16'(count),     16'(c));
        chk({tag, ".full"},      16'(full),      16'(f));
        chk({tag, ".overflow"},  16'(overflow),  16'(o));
    endtask

    task automatic cycle(input logic l, input logic [DW-1:0] a, input logic r);
        load      = l;
        acc_in    = a;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic l, input logic [DW-1:0] a, input logic r, input logic v,
                       input logic [DW-1:0] d, input logic [AW:0] c, input logic f, input logic o);
        vec_t t;
        t.load = l; t.acc = a; t.rdy = r;
        t.exp_valid = v; t.exp_data = d; t.exp_count = c; t.exp_full = f; t.exp_ovf = o;
        vecs.push_back(t);
    endtask

    // Reference model state: plain queue plus sticky flag.
    logic [DW-1:0] mq [$];
    logic          m_ovf;

    initial begin
        reset = 1'b1; load = 1'b0; acc_in = '0; out_ready = 1'b0;
        m_ovf = 1'b0;

        #2;
        chk_all("reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single transfer, full push/pop, drain, empty-side simultaneity.
        add(1, 8'hCC, 0,  1, 8'hCC, 1, 0, 0);
        add(0, 8'h00, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'h11, 0,  1, 8'h11, 1, 0, 0);
        add(1, 8'h22, 0,  1, 8'h11, 2, 0, 0);
        add(1, 8'h33, 0,  1, 8'h11, 3, 0, 0);
        add(1, 8'h44, 0,  1, 8'h11, 4, 1, 0);
        add(0, 8'h00, 0,  1, 8'h11, 4, 1, 0);
        add(1, 8'hC8, 1,  1, 8'h22, 4, 1, 0);
        add(0, 8'h00, 1,  1, 8'h33, 3, 0, 0);
        add(0, 8'h00, 1,  1, 8'h44, 2, 0, 0);
        add(0, 8'h00, 1,  1, 8'hC8, 1, 0, 0);
        add(0, 8'h00, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'hA5, 1,  1, 8'hA5, 1, 0, 0);
        add(0, 8'h00, 1,  0, 8'h00, 0, 0, 0);
        // Fill, hold under backpressure, overflow drop, ordered drain.
        add(1, 8'h11, 0,  1, 8'h11, 1, 0, 0);
        add(1, 8'h22, 0,  1, 8'h11, 2, 0, 0);
        add(1, 8'h33, 0,  1, 8'h11, 3, 0, 0);
        add(1, 8'h44, 0,  1, 8'h11, 4, 1, 0);
        add(0, 8'h00, 0,  1, 8'h11, 4, 1, 0);
        add(1, 8'h55, 0,  1, 8'h11, 4, 1, 1);
        add(0, 8'h00, 1,  1, 8'h22, 3, 0, 1);
        add(0, 8'h00, 1,  1, 8'h33, 2, 0, 1);
        add(0, 8'h00, 1,  1, 8'h44, 1, 0, 1);
        add(0, 8'h00, 1,  0, 8'h00, 0, 0, 1);

        foreach (vecs[i]) begin
            cycle(vecs[i].load, vecs[i].acc, vecs[i].rdy);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                    vecs[i].exp_count, vecs[i].exp_full, vecs[i].exp_ovf);
        end

        // Async reset between edges with two words stored and overflow set.
        cycle(1, 8'h61, 0);
        cycle(1, 8'h62, 0);
        chk("pre_reset.count", 16'(count), 16'd2);
        load = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Streaming across pointer wrap: each word visible one cycle after its push.
        for (int k = 1; k <= 10; k++) begin
            cycle(1, 8'(k), 1);
            chk_all($sformatf("stream%0d", k), 1'b1, 8'(k), 3'd1, 1'b0, 1'b0);
        end
        cycle(0, 8'h00, 1);
        chk_all("stream_end", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        // Random traffic against the queue model; acc_in is X whenever load is low.
        for (int n = 0; n < 400; n++) begin
            logic l, r, pop_m, full_m;
            logic [DW-1:0] a;
            l = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            a = 8'($urandom);
            full_m = (mq.size() == DEPTH);
            pop_m  = r && (mq.size() != 0);
            if (pop_m) void'(mq.pop_front());
            if (l) begin
                if (!full_m || pop_m) mq.push_back(a);
                else m_ovf = 1'b1;
            end
            cycle(l, l ? a : 'x, r);
            chk_all($sformatf("rnd%0d", n), mq.size() != 0,
                    (mq.size() != 0) ? mq[0] : 8'h00,
                    (AW+1)'(mq.size()), mq.size() == DEPTH, m_ovf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
